// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO that decouples a producer and a consumer
// sharing one clock domain.
//
// Ports:
//   clock   - sole clock; all state changes on its rising edge
//   reset   - asynchronous, active-low clear of pointers, count and dataout
//   wn      - write enable; datain is captured on the rising edge
//   rn      - read enable; one word is popped on the rising edge
//   datain  - write data
//   dataout - registered read data; holds its value when no read is accepted
//   full    - occupancy == DEPTH
//   empty   - occupancy == 0
//
// Writes when full (without a read) and reads when empty are silently dropped.
// The storage array itself is not reset.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wn,
    input  logic                  rn,
    input  logic [DATA_WIDTH-1:0] datain,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic [DATA_WIDTH-1:0] dataout_q, dataout_d;

    logic wr_en;
    logic rd_en;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign dataout = dataout_q;

    always_comb begin
        // A read on a full FIFO frees the slot the write lands in, so a write
        // is allowed when full as long as a read happens on the same edge.
        wr_en     = wn && (!full || rn);
        rd_en     = rn && !empty;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dataout_d = dataout_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            dataout_d = mem_q[rd_ptr_q];
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dataout_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dataout_q <= dataout_d;
        end
    end

    // Storage is deliberately left out of reset. When full with a simultaneous
    // read and write, wr_ptr == rd_ptr; the read above samples the old word
    // before this edge overwrites it.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wn    = 1'b0;
    logic          rn    = 1'b0;
    logic [DW-1:0] datain = '0;
    logic [DW-1:0] dataout;
    logic          full;
    logic          empty;

    int tests = 0;
    int fails = 0;

    // Reference model: an ordered queue of stored words plus the last word read.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] dout_m = '0;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .wn     (wn),
        .rn     (rn),
        .datain (datain),
        .dataout(dataout),
        .full   (full),
        .empty  (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_dataout"}, dataout, dout_m);
        check({tag, "_full"}, {31'd0, full}, {31'd0, model_q.size() == DEPTH});
        check({tag, "_empty"}, {31'd0, empty}, {31'd0, model_q.size() == 0});
    endtask

    // One clock: drive strobes at the falling edge, update the model at the
    // rising edge, compare shortly after it.
    task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        bit was_full;
        bit wr_ok;
        bit rd_ok;
        @(negedge clock);
        wn     = w;
        rn     = r;
        datain = d;
        @(posedge clock);
        was_full = (model_q.size() == DEPTH);
        wr_ok    = w && (!was_full || r);
        rd_ok    = r && (model_q.size() != 0);
        if (rd_ok) dout_m = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        #1;
        check_status(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        dout_m = '0;
    endtask

    initial begin
        // Reset held low while clocking, with strobes active: nothing may move.
        wn = 1'b1; rn = 1'b1; datain = 32'h1234_5678;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        check_status("reset_hold");
        @(negedge clock);
        wn = 1'b0; rn = 1'b0;
        reset = 1'b1;

        // Fill with seven words, then drain and one extra read on empty.
        step("fill", 1, 0, 32'd10);
        step("fill", 1, 0, 32'd15);
        step("fill", 1, 0, 32'd20);
        step("fill", 1, 0, 32'd30);
        step("fill", 1, 0, 32'd35);
        step("fill", 1, 0, 32'd40);
        step("fill", 1, 0, 32'd45);
        for (int i = 0; i < 8; i++) step("drain", 0, 1, '0);
        check("drain_hold_45", dataout, 32'd45);

        // Full boundary: 1..8 then an ignored 99, drain returns 1..8.
        for (int i = 1; i <= 8; i++) step("fill8", 1, 0, DW'(i));
        step("write_on_full", 1, 0, 32'd99);
        for (int i = 0; i < 8; i++) step("drain8", 0, 1, '0);
        check("drain8_last", dataout, 32'd8);
        step("drain8_extra", 0, 1, '0);

        // Empty boundary: read on empty, then a write does not fall through.
        step("read_on_empty", 0, 1, '0);
        step("write_no_fallthru", 1, 0, 32'hDEAD_BEEF);
        check("no_fallthru", dataout, 32'd8);
        step("read_deadbeef", 0, 1, '0);
        check("deadbeef", dataout, 32'hDEAD_BEEF);

        // Simultaneous access on a full FIFO.
        for (int i = 0; i < 8; i++) step("fill_sim", 1, 0, 32'h100 + DW'(i));
        step("sim_full", 1, 1, 32'hA5A5_A5A5);
        check("sim_full_oldest", dataout, 32'h100);
        for (int i = 0; i < 8; i++) step("drain_sim", 0, 1, '0);
        check("a5_last", dataout, 32'hA5A5_A5A5);

        // Simultaneous access on an empty FIFO: only the write happens.
        step("sim_empty", 1, 1, 32'h0BAD_F00D);
        check("sim_empty_hold", dataout, 32'hA5A5_A5A5);
        step("sim_empty_read", 0, 1, '0);

        // Wrap-around with interleaved traffic, some of it simultaneous.
        for (int i = 0; i < 20; i++) begin
            step("wrap_w", 1, 0, 32'h2000 + DW'(i));
            step("wrap_r", 0, 1, '0);
        end
        for (int i = 0; i < 3; i++) step("wrap_pre", 1, 0, 32'h3000 + DW'(i));
        for (int i = 0; i < 20; i++) step("wrap_sim", 1, 1, 32'h3100 + DW'(i));
        for (int i = 0; i < 4; i++) step("wrap_drain", 0, 1, '0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom);
        end

        // Asynchronous reset mid-operation, between clock edges.
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 32'h4000 + DW'(i));
        step("pre_rst_rd", 0, 1, '0);
        @(negedge clock);
        wn = 1'b0; rn = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_status("async_rst");
        @(negedge clock);
        reset = 1'b1;
        step("post_rst_w", 1, 0, 32'h5555_0001);
        step("post_rst_r", 0, 1, '0);
        check("post_rst_data", dataout, 32'h5555_0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
